comb_resp_checker: RTL and testbench
====================================

Name: comb_resp_checker

Overview:
- Response-side companion to the exhaustive stimulus sweeps used for the combinational blocks in this codebase. The stimulus side drives every input code to a DUT such as comb_Y1; this block receives each applied vector and the DUT's output, and compares the output with a parameterised truth table.
- It counts mismatches, captures the first failing vector, flags out-of-order vectors, compacts all responses into an 8-bit MISR signature, and reports pass/fail when the sweep completes.
- It sits next to the DUT, in a bench or a hardware self-test wrapper.

Parameters:
- N, 3, DUT input width; a sweep is 2^N vectors.
- TRUTH, 8'b1110_1000, expected output table, width 2^N. Bit i is the expected Y for input code i. Default is 3-input majority.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a sweep.
- vec_valid  input  1  vec/y are valid this cycle.
- vec  input  N  input code applied to the DUT.
- y  input  1  DUT output for vec.
- busy  output  1  sweep in progress.
- done  output  1  sweep complete; results stable.
- pass  output  1  valid when done; 1 = no mismatches and no order error.
- err_cnt  output  N+1  number of mismatching vectors.
- seq_err  output  1  a vector arrived out of ascending order.
- first_fail_valid  output  1  first_fail_vec holds a captured failure.
- first_fail_vec  output  N  code of the first mismatching vector.
- sig  output  8  MISR signature of the y stream.

Behaviour:
- Reset (async, immediate): state IDLE. busy, done, pass, seq_err and first_fail_valid are 0. err_cnt, first_fail_vec and sig are 0. The internal index counter idx is 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start -> RUN on the next edge.
  - Entering RUN clears idx, err_cnt, seq_err, first_fail_*, sig and pass.
  - vec_valid is ignored.
- RUN, busy=1. A beat is accepted on every cycle with vec_valid=1:
  - Mismatch = (y != TRUTH[vec]), using the received vec, not idx. On mismatch err_cnt increments. If first_fail_valid=0, first_fail_vec<=vec and first_fail_valid<=1.
  - If vec != idx, seq_err<=1. It is sticky for the rest of the sweep.
  - MISR update: sig <= {sig[6:0],1'b0} ^ (sig[7] ? 8'h1D : 8'h00) ^ {7'b0,y}.
  - idx increments by 1 on each accepted beat.
  - When the beat with idx == 2^N-1 is accepted, go to DONE on the same edge. All updates from that final beat are included.
  - Gaps (vec_valid=0) are allowed: no state change.
  - start during RUN is ignored; the sweep is not restarted.
- DONE: busy=0, done=1.
  - pass = (err_cnt==0) && !seq_err, registered on entry to DONE.
  - Results hold until start or rst. vec_valid is ignored.
  - start -> RUN, with the same clearing as from IDLE; done drops on that edge.
- Latency: err_cnt, sig and first_fail_* reflect a beat one cycle after the edge it is sampled on. done/pass assert the cycle after the final beat's edge.
- Width rules:
  - err_cnt max is 2^N, so N+1 bits never wraps.
  - idx is N+1 bits internally. The end of sweep is detected on the count of accepted beats, not on the vec value.
- Reset mid-RUN: everything is cleared asynchronously and the FSM returns to IDLE. Partial results are discarded.
- Simultaneous start and vec_valid in IDLE/DONE: start takes effect; the vec_valid beat is not accepted.

Test Plan:
1. Reset, start, then 8 beats vec=0..7 with y=majority(vec) -> done=1, pass=1, err_cnt=0, seq_err=0, first_fail_valid=0.
2. Same sweep but y inverted at vec=2 and vec=5 -> err_cnt=2, first_fail_vec=3'd2, first_fail_valid=1, pass=0.
3. Sweep with y=0 on every beat and TRUTH=8'h00 -> sig=8'h00, pass=1. Sweep with y=1 on every beat -> sig equals the bench's reference MISR model, and err_cnt=4 against the default TRUTH.
4. Vectors sent 0,1,3,2,4,5,6,7 with correct y -> seq_err=1, err_cnt=0, pass=0, done after the 8th beat.
5. Random vec_valid gaps during a correct sweep, plus start pulsed mid-RUN -> identical result to scenario 1 with no restart; busy stays high until the 8th beat.
6. rst asserted after 4 beats, asynchronously between edges -> all outputs 0 immediately. A fresh start and full correct sweep -> pass=1.

Source files
------------

// File: rtl/comb_resp_checker.sv
// Response checker for exhaustive combinational sweeps: compares each
// received (vec, y) beat against a truth table, counts mismatches, captures
// the first failing code, flags out-of-order codes and compacts y into a MISR.
module comb_resp_checker #(
  parameter int unsigned        N     = 3,
  parameter logic [(1<<N)-1:0]  TRUTH = 8'b1110_1000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         vec_valid,
  input  logic [N-1:0] vec,
  input  logic         y,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N:0]   err_cnt,
  output logic         seq_err,
  output logic         first_fail_valid,
  output logic [N-1:0] first_fail_vec,
  output logic [7:0]   sig
);

  localparam int unsigned CW   = N + 1;
  localparam logic [N:0]  LAST = CW'((1 << N) - 1);
  localparam logic [7:0]  POLY = 8'h1D;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state_q, state_d;
  logic [N:0] idx_q;
  logic       beat, clear, last_beat, mismatch, seq_nx;
  logic [N:0] err_nx;

  // Next-state decode; a sweep ends on the beat count, not on the vec value
  always_comb begin
    state_d   = state_q;
    beat      = 1'b0;
    clear     = 1'b0;
    last_beat = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          clear   = 1'b1;
        end
      end
      RUN: begin
        if (vec_valid) begin
          beat = 1'b1;
          if (idx_q == LAST) begin
            last_beat = 1'b1;
            state_d   = DONE;
          end
        end
      end
      DONE: begin
        if (start) begin
          state_d = RUN;
          clear   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Per-beat comparison results, used both for update and for the final pass
  always_comb begin
    mismatch = (y != TRUTH[vec]);
    err_nx   = err_cnt + CW'(mismatch);
    seq_nx   = seq_err | (CW'(vec) != idx_q);
  end

  // State register and registered status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d == RUN);
      done    <= (state_d == DONE);
    end
  end

  // Result datapath: cleared when a sweep starts, updated on accepted beats
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q            <= '0;
      err_cnt          <= '0;
      seq_err          <= 1'b0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
      sig              <= '0;
      pass             <= 1'b0;
    end else if (clear) begin
      idx_q            <= '0;
      err_cnt          <= '0;
      seq_err          <= 1'b0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
      sig              <= '0;
      pass             <= 1'b0;
    end else if (beat) begin
      idx_q   <= idx_q + CW'(1);
      err_cnt <= err_nx;
      seq_err <= seq_nx;
      sig     <= {sig[6:0], 1'b0} ^ (sig[7] ? POLY : 8'h00) ^ {7'b0, y};
      if (mismatch && !first_fail_valid) begin
        first_fail_valid <= 1'b1;
        first_fail_vec   <= vec;
      end
      if (last_beat) begin
        pass <= (err_nx == '0) && !seq_nx;
      end
    end
  end

endmodule

// File: tb/tb_comb_resp_checker.sv
// Bench for comb_resp_checker: table of sweeps, expected results queued on
// drive and compared when done rises; plus reset/hold corner sequences.
module tb_comb_resp_checker;

  logic       clk = 1'b0;
  logic       rst, start, vec_valid, y;
  logic [2:0] vec;

  logic       a_busy, a_done, a_pass, a_seq_err, a_ffv;
  logic [3:0] a_err_cnt;
  logic [2:0] a_ffvec;
  logic [7:0] a_sig;
  logic       b_busy, b_done, b_pass, b_seq_err, b_ffv;
  logic [3:0] b_err_cnt;
  logic [2:0] b_ffvec;
  logic [7:0] b_sig;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  // Default majority table
  comb_resp_checker #(.N(3)) dut_a (
    .clk(clk), .rst(rst), .start(start), .vec_valid(vec_valid), .vec(vec), .y(y),
    .busy(a_busy), .done(a_done), .pass(a_pass), .err_cnt(a_err_cnt),
    .seq_err(a_seq_err), .first_fail_valid(a_ffv), .first_fail_vec(a_ffvec), .sig(a_sig)
  );

  // All-zero table
  comb_resp_checker #(.N(3), .TRUTH(8'h00)) dut_b (
    .clk(clk), .rst(rst), .start(start), .vec_valid(vec_valid), .vec(vec), .y(y),
    .busy(b_busy), .done(b_done), .pass(b_pass), .err_cnt(b_err_cnt),
    .seq_err(b_seq_err), .first_fail_valid(b_ffv), .first_fail_vec(b_ffvec), .sig(b_sig)
  );

  typedef struct {
    logic [23:0] order;     // slot k at [3k+:3]
    logic [7:0]  ypat;      // bit k = y on beat k
    bit          gaps;
    bit          mid_start;
    logic [3:0]  err;
    bit          seq;
    bit          ffv;
    logic [2:0]  ffvec;
    bit          pass;
  } vec_t;

  typedef struct {
    logic [3:0] err_a;
    bit         seq;
    bit         ffv_a;
    logic [2:0] ffvec_a;
    bit         pass_a;
    logic [7:0] sig;
    logic [3:0] err_b;
    bit         ffv_b;
    logic [2:0] ffvec_b;
    bit         pass_b;
  } exp_t;

  vec_t tbl[6];
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] misr(input logic [7:0] ypat);
    logic [7:0] s = 8'h00;
    for (int k = 0; k < 8; k++)
      s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00) ^ {7'b0, ypat[k]};
    return s;
  endfunction

  // Build the expectation record for one table entry
  function automatic exp_t make_exp(input vec_t t);
    exp_t x;
    x.err_a = t.err; x.seq = t.seq; x.ffv_a = t.ffv; x.ffvec_a = t.ffvec; x.pass_a = t.pass;
    x.sig = misr(t.ypat);
    x.err_b = 4'd0; x.ffv_b = 1'b0; x.ffvec_b = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (t.ypat[k]) begin
        x.err_b++;
        if (!x.ffv_b) begin
          x.ffv_b   = 1'b1;
          x.ffvec_b = t.order[3*k +: 3];
        end
      end
    end
    x.pass_b = (x.err_b == 4'd0) && !t.seq;
    return x;
  endfunction

  task automatic drive_start();
    // A colliding beat with a wrong y must not be accepted
    start = 1'b1; vec_valid = 1'b1; vec = 3'd0; y = 1'b1;
    tick();
    start = 1'b0; vec_valid = 1'b0;
    chk("busy_after_start", {a_busy, a_done, a_err_cnt}, {1'b1, 1'b0, 4'd0});
  endtask

  task automatic run_sweep(input int e);
    vec_t t = tbl[e];
    sb.push_back(make_exp(t));
    drive_start();
    for (int k = 0; k < 8; k++) begin
      if (t.gaps) repeat ($urandom_range(0, 2)) tick();
      vec_valid = 1'b1;
      vec       = t.order[3*k +: 3];
      y         = t.ypat[k];
      start     = t.mid_start && (k == 4);
      tick();
      vec_valid = 1'b0;
      start     = 1'b0;
      if (t.gaps && k < 7) chk($sformatf("busy_mid_%0d", k), a_busy, 1'b1);
    end
    check_done(e);
  endtask

  task automatic check_done(input int e);
    exp_t x;
    int   w = 0;
    while (!a_done && w < 10) begin
      @(negedge clk);
      w++;
    end
    x = sb.pop_front();
    chk($sformatf("s%0d_done", e), {a_done, a_busy, b_done}, {1'b1, 1'b0, 1'b1});
    chk($sformatf("s%0d_done_lat", e), w, 0);
    chk($sformatf("s%0d_a_err", e), a_err_cnt, x.err_a);
    chk($sformatf("s%0d_a_seq", e), a_seq_err, x.seq);
    chk($sformatf("s%0d_a_ff", e), {a_ffv, a_ffvec}, {x.ffv_a, x.ffvec_a});
    chk($sformatf("s%0d_a_pass", e), a_pass, x.pass_a);
    chk($sformatf("s%0d_a_sig", e), a_sig, x.sig);
    chk($sformatf("s%0d_b_err", e), b_err_cnt, x.err_b);
    chk($sformatf("s%0d_b_ff", e), {b_ffv, b_ffvec}, {x.ffv_b, x.ffvec_b});
    chk($sformatf("s%0d_b_pass", e), b_pass, x.pass_b);
    chk($sformatf("s%0d_b_sig", e), b_sig, x.sig);
    // Results hold in DONE while stray beats arrive
    vec_valid = 1'b1; vec = 3'd0; y = 1'b1;
    repeat (2) tick();
    vec_valid = 1'b0;
    chk($sformatf("s%0d_hold", e), {a_done, a_err_cnt, a_sig}, {1'b1, x.err_a, x.sig});
  endtask

  localparam logic [23:0] ORD_INC  = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
  localparam logic [23:0] ORD_SWAP = {3'd7, 3'd6, 3'd5, 3'd4, 3'd2, 3'd3, 3'd1, 3'd0};

  initial begin
    //          order     ypat   gaps mid   err  seq  ffv  ffvec pass
    tbl[0] = '{ORD_INC,  8'hE8, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 3'd0, 1'b1};
    tbl[1] = '{ORD_INC,  8'hCC, 1'b0, 1'b0, 4'd2, 1'b0, 1'b1, 3'd2, 1'b0};
    tbl[2] = '{ORD_INC,  8'h00, 1'b0, 1'b0, 4'd4, 1'b0, 1'b1, 3'd3, 1'b0};
    tbl[3] = '{ORD_INC,  8'hFF, 1'b0, 1'b0, 4'd4, 1'b0, 1'b1, 3'd0, 1'b0};
    tbl[4] = '{ORD_SWAP, 8'hE4, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 3'd0, 1'b0};
    tbl[5] = '{ORD_INC,  8'hE8, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 3'd0, 1'b1};

    rst = 1'b1; start = 1'b0; vec_valid = 1'b0; vec = 3'd0; y = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_flags", {a_busy, a_done, a_pass, a_seq_err, a_ffv}, 5'b0);
    chk("reset_data", {a_err_cnt, a_ffvec, a_sig}, 15'b0);
    rst = 1'b0;
    @(negedge clk);
    // Beats in IDLE are ignored
    vec_valid = 1'b1; y = 1'b1;
    tick();
    vec_valid = 1'b0;
    chk("idle_ignore", {a_busy, a_err_cnt, a_sig}, 13'b0);

    for (int e = 0; e < 6; e++) run_sweep(e);

    // Async reset partway through a sweep with one mismatch already seen
    drive_start();
    for (int k = 0; k < 4; k++) begin
      vec_valid = 1'b1; vec = 3'(k); y = tbl[1].ypat[k];
      tick();
    end
    vec_valid = 1'b0;
    chk("pre_rst", {a_busy, a_err_cnt, a_ffv}, {1'b1, 4'd1, 1'b1});
    #2 rst = 1'b1;
    #1;
    chk("rst_async_flags", {a_busy, a_done, a_pass, a_seq_err, a_ffv}, 5'b0);
    chk("rst_async_data", {a_err_cnt, a_ffvec, a_sig}, 15'b0);
    #1 rst = 1'b0;
    @(negedge clk);
    run_sweep(0);

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
